// File: rtl/fetch_pc_unit.sv
// PC register and single-outstanding instruction fetch sequencer (REQ -> WAIT -> HOLD).
// Buffers one fetched word for decode, counts retirements and traps misaligned redirects.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        NextPCSrc,
   input  logic [31:0] ALURes,
   input  logic        Stall,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemGnt,
   input  logic        IMemRvalid,
   input  logic [31:0] IMemRdata,
   output logic        InstValid,
   output logic [31:0] Inst,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        MisalignTrap,
   output logic [31:0] InstRet
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] instret_q, instret_d;
   logic        trap_q, trap_d;
   // Keeps the request low while in reset; set by the first edge after release.
   logic        req_en_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         inst_q    <= NOP;
         instret_q <= 32'd0;
         trap_q    <= 1'b0;
         req_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         instret_q <= instret_d;
         trap_q    <= trap_d;
         req_en_q  <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      instret_d = instret_q;
      trap_d    = 1'b0;
      case (state_q)
         S_REQ: begin
            // Rvalid without a grant belongs to an aborted request and is dropped.
            if (req_en_q && IMemGnt) begin
               if (IMemRvalid) begin
                  inst_d  = IMemRdata;
                  state_d = S_HOLD;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (IMemRvalid) begin
               inst_d  = IMemRdata;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!Stall) begin
               instret_d = instret_q + 32'd1;
               state_d   = S_REQ;
               if (!NextPCSrc) begin
                  pc_d = pc_q + PC_STEP;
               end else if (ALURes[1:0] == 2'b00) begin
                  pc_d = {ALURes[31:1], 1'b0};
               end else begin
                  pc_d   = TRAP_PC;
                  trap_d = 1'b1;
               end
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   assign IMemReq      = req_en_q && (state_q == S_REQ);
   assign IMemAddr     = pc_q;
   assign InstValid    = (state_q == S_HOLD);
   assign Inst         = inst_q;
   assign PC           = pc_q;
   assign PCPlus4      = pc_q + PC_STEP;
   assign MisalignTrap = trap_q;
   assign InstRet      = instret_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: inputs driven and outputs sampled on the falling edge,
// expected values hand-computed per scenario.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        NextPCSrc;
   logic [31:0] ALURes;
   logic        Stall;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemGnt;
   logic        IMemRvalid;
   logic [31:0] IMemRdata;
   logic        InstValid;
   logic [31:0] Inst;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        MisalignTrap;
   logic [31:0] InstRet;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   fetch_pc_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .NextPCSrc    (NextPCSrc),
      .ALURes       (ALURes),
      .Stall        (Stall),
      .IMemReq      (IMemReq),
      .IMemAddr     (IMemAddr),
      .IMemGnt      (IMemGnt),
      .IMemRvalid   (IMemRvalid),
      .IMemRdata    (IMemRdata),
      .InstValid    (InstValid),
      .Inst         (Inst),
      .PC           (PC),
      .PCPlus4      (PCPlus4),
      .MisalignTrap (MisalignTrap),
      .InstRet      (InstRet)
   );

   // Stimulus only: from a REQ cycle, answer with grant+data in the same cycle.
   task automatic zw_fetch(input logic [31:0] data);
      $display("[TB] fetch addr=%h data=%h", IMemAddr, data);
      IMemGnt = 1'b1; IMemRvalid = 1'b1; IMemRdata = data;
      @(posedge clk); @(negedge clk);
      IMemGnt = 1'b0; IMemRvalid = 1'b0;
   endtask

   // Stimulus only: from a HOLD cycle, retire with the given redirect.
   task automatic retire(input logic src, input logic [31:0] alu);
      $display("[TB] retire pc=%h src=%0d alu=%h", PC, src, alu);
      Stall = 1'b0; NextPCSrc = src; ALURes = alu;
      @(posedge clk); @(negedge clk);
      NextPCSrc = 1'b0; ALURes = 32'd0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; NextPCSrc = 1'b0; ALURes = 32'd0; Stall = 1'b0;
      IMemGnt = 1'b0; IMemRvalid = 1'b0; IMemRdata = 32'd0;
      repeat (2) @(negedge clk);
      tests_run++; if (IMemReq !== 1'b0) begin tests_failed++; $display("FAIL rst_req: got %b exp 0", IMemReq); end
      tests_run++; if (InstValid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b exp 0", InstValid); end
      tests_run++; if (PC !== 32'h0) begin tests_failed++; $display("FAIL rst_pc: got %h exp 0", PC); end
      tests_run++; if (Inst !== 32'h13) begin tests_failed++; $display("FAIL rst_inst: got %h exp 00000013", Inst); end
      tests_run++; if (InstRet !== 32'h0) begin tests_failed++; $display("FAIL rst_instret: got %h exp 0", InstRet); end
      tests_run++; if (MisalignTrap !== 1'b0) begin tests_failed++; $display("FAIL rst_trap: got %b exp 0", MisalignTrap); end
      rst_n = 1'b1;
      @(negedge clk);
      $display("[TB] reset released");
   endtask

   task automatic test_sequential;
      logic [31:0] exp_addr;
      for (int i = 0; i < 4; i++) begin
         exp_addr = 32'(i * 4);
         tests_run++; if (IMemReq !== 1'b1) begin tests_failed++; $display("FAIL seq_req%0d: got %b exp 1", i, IMemReq); end
         tests_run++; if (IMemAddr !== exp_addr) begin tests_failed++; $display("FAIL seq_addr%0d: got %h exp %h", i, IMemAddr, exp_addr); end
         tests_run++; if (InstValid !== 1'b0) begin tests_failed++; $display("FAIL seq_novalid%0d: got %b exp 0", i, InstValid); end
         zw_fetch(32'h0000_0013);
         tests_run++; if (InstValid !== 1'b1) begin tests_failed++; $display("FAIL seq_valid%0d: got %b exp 1", i, InstValid); end
         tests_run++; if (PC !== exp_addr) begin tests_failed++; $display("FAIL seq_pc%0d: got %h exp %h", i, PC, exp_addr); end
         retire(1'b0, 32'd0);
      end
      tests_run++; if (InstRet !== 32'd4) begin tests_failed++; $display("FAIL seq_instret: got %0d exp 4", InstRet); end
   endtask

   task automatic test_branch;
      tests_run++; if (IMemAddr !== 32'h10) begin tests_failed++; $display("FAIL br_pre_addr: got %h exp 00000010", IMemAddr); end
      zw_fetch(32'hAAAA_0001);
      retire(1'b1, 32'h40);
      tests_run++; if (IMemAddr !== 32'h40) begin tests_failed++; $display("FAIL br_addr: got %h exp 00000040", IMemAddr); end
      tests_run++; if (InstRet !== 32'd5) begin tests_failed++; $display("FAIL br_instret: got %0d exp 5", InstRet); end
      zw_fetch(32'hAAAA_0002);
      tests_run++; if (PC !== 32'h40) begin tests_failed++; $display("FAIL br_pc: got %h exp 00000040", PC); end
      tests_run++; if (PCPlus4 !== 32'h44) begin tests_failed++; $display("FAIL br_pcplus4: got %h exp 00000044", PCPlus4); end
      tests_run++; if (Inst !== 32'hAAAA_0002) begin tests_failed++; $display("FAIL br_inst: got %h exp aaaa0002", Inst); end
   endtask

   task automatic test_misalign;
      tests_run++; if (MisalignTrap !== 1'b0) begin tests_failed++; $display("FAIL mis_pre: got %b exp 0", MisalignTrap); end
      retire(1'b1, 32'h42);
      tests_run++; if (MisalignTrap !== 1'b1) begin tests_failed++; $display("FAIL mis_pulse: got %b exp 1", MisalignTrap); end
      tests_run++; if (IMemAddr !== 32'h100) begin tests_failed++; $display("FAIL mis_addr: got %h exp 00000100", IMemAddr); end
      tests_run++; if (InstRet !== 32'd6) begin tests_failed++; $display("FAIL mis_instret: got %0d exp 6", InstRet); end
      @(negedge clk);
      tests_run++; if (MisalignTrap !== 1'b0) begin tests_failed++; $display("FAIL mis_end: got %b exp 0", MisalignTrap); end
      tests_run++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h100) begin tests_failed++; $display("FAIL mis_nognt: got req=%b addr=%h exp req=1 addr=00000100", IMemReq, IMemAddr); end
   endtask

   task automatic test_stall;
      zw_fetch(32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         Stall = 1'b1; NextPCSrc = (i != 1); ALURes = 32'h83;
         @(posedge clk); @(negedge clk);
         $display("[TB] stall cycle %0d src=%0d", i, NextPCSrc);
         tests_run++; if (InstValid !== 1'b1 || Inst !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL st_inst%0d: got v=%b %h exp v=1 deadbeef", i, InstValid, Inst); end
         tests_run++; if (PC !== 32'h100 || InstRet !== 32'd6) begin tests_failed++; $display("FAIL st_pc%0d: got pc=%h ret=%0d exp pc=00000100 ret=6", i, PC, InstRet); end
         tests_run++; if (MisalignTrap !== 1'b0) begin tests_failed++; $display("FAIL st_trap%0d: got %b exp 0", i, MisalignTrap); end
      end
      retire(1'b0, 32'd0);
      tests_run++; if (IMemAddr !== 32'h104 || InstRet !== 32'd7) begin tests_failed++; $display("FAIL st_release: got addr=%h ret=%0d exp addr=00000104 ret=7", IMemAddr, InstRet); end
   endtask

   task automatic test_slow_mem;
      for (int i = 0; i < 3; i++) begin
         tests_run++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h104) begin tests_failed++; $display("FAIL sm_req%0d: got req=%b addr=%h exp req=1 addr=00000104", i, IMemReq, IMemAddr); end
         IMemGnt = (i == 2); IMemRvalid = (i == 1); IMemRdata = 32'h0000_0BAD;
         @(posedge clk); @(negedge clk);
      end
      IMemGnt = 1'b0; IMemRvalid = 1'b0;
      $display("[TB] slow grant at addr 00000104");
      for (int i = 0; i < 3; i++) begin
         tests_run++; if (IMemReq !== 1'b0 || InstValid !== 1'b0) begin tests_failed++; $display("FAIL sm_wait%0d: got req=%b v=%b exp 0 0", i, IMemReq, InstValid); end
         IMemRvalid = (i == 2); IMemRdata = 32'h1234_5678;
         @(posedge clk); @(negedge clk);
      end
      IMemRvalid = 1'b0;
      tests_run++; if (InstValid !== 1'b1 || Inst !== 32'h1234_5678) begin tests_failed++; $display("FAIL sm_capture: got v=%b %h exp v=1 12345678", InstValid, Inst); end
      Stall = 1'b1; IMemRvalid = 1'b1; IMemRdata = 32'h0000_0055;
      @(posedge clk); @(negedge clk);
      IMemRvalid = 1'b0;
      tests_run++; if (Inst !== 32'h1234_5678 || PC !== 32'h104) begin tests_failed++; $display("FAIL sm_single: got inst=%h pc=%h exp 12345678 00000104", Inst, PC); end
      retire(1'b0, 32'd0);
      tests_run++; if (IMemAddr !== 32'h108 || InstRet !== 32'd8) begin tests_failed++; $display("FAIL sm_next: got addr=%h ret=%0d exp 00000108 8", IMemAddr, InstRet); end
   endtask

   task automatic test_wrap;
      zw_fetch(32'h0000_0013);
      retire(1'b1, 32'hFFFF_FFFC);
      tests_run++; if (IMemAddr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wr_addr: got %h exp fffffffc", IMemAddr); end
      zw_fetch(32'h0000_0013);
      tests_run++; if (PCPlus4 !== 32'h0) begin tests_failed++; $display("FAIL wr_pcplus4: got %h exp 0", PCPlus4); end
      retire(1'b0, 32'd0);
      tests_run++; if (IMemAddr !== 32'h0 || InstRet !== 32'd10) begin tests_failed++; $display("FAIL wr_seq: got addr=%h ret=%0d exp 0 10", IMemAddr, InstRet); end
   endtask

   task automatic test_reset_mid_fetch;
      IMemGnt = 1'b1; IMemRvalid = 1'b0;
      @(posedge clk); @(negedge clk);
      IMemGnt = 1'b0;
      tests_run++; if (IMemReq !== 1'b0) begin tests_failed++; $display("FAIL rm_inwait: got %b exp 0", IMemReq); end
      rst_n = 1'b0;
      #1;
      $display("[TB] reset asserted during WAIT");
      tests_run++; if (PC !== 32'h0 || InstRet !== 32'h0 || IMemReq !== 1'b0) begin tests_failed++; $display("FAIL rm_async: got pc=%h ret=%0d req=%b exp 0 0 0", PC, InstRet, IMemReq); end
      @(negedge clk);
      rst_n = 1'b1;
      IMemRvalid = 1'b1; IMemRdata = 32'h00BA_DBAD;
      @(posedge clk); @(negedge clk);
      IMemRvalid = 1'b0;
      tests_run++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin tests_failed++; $display("FAIL rm_req: got req=%b addr=%h exp 1 0", IMemReq, IMemAddr); end
      tests_run++; if (InstValid !== 1'b0 || Inst !== 32'h13) begin tests_failed++; $display("FAIL rm_drop: got v=%b inst=%h exp 0 00000013", InstValid, Inst); end
      @(negedge clk);
      tests_run++; if (InstValid !== 1'b0) begin tests_failed++; $display("FAIL rm_still: got %b exp 0", InstValid); end
      zw_fetch(32'hCAFE_0013);
      tests_run++; if (InstValid !== 1'b1 || Inst !== 32'hCAFE_0013 || PC !== 32'h0) begin tests_failed++; $display("FAIL rm_fetch: got v=%b inst=%h pc=%h exp 1 cafe0013 0", InstValid, Inst, PC); end
   endtask

   initial begin
      test_reset;
      test_sequential;
      test_branch;
      test_misalign;
      test_stall;
      test_slow_mem;
      test_wrap;
      test_reset_mid_fetch;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
